ecc_enc_pipe: RTL and testbench

ECC_ENC_PIPE -- requirements
Module: ecc_enc_pipe

---
 rtl/ecc_enc_pipe.sv | 150 +++++++++++++++
 tb/tb_ecc_enc_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_enc_pipe.sv
// Two-stage SECDED (extended Hamming) encoder pipeline.
// Multi-lane, valid/ready on both sides, with optional error injection.
module ecc_enc_pipe #(
  parameter int K      = 32,
  parameter int LANES  = 2,
  parameter int P0_LSB = 1,
  parameter int CNT_W  = 32,
  localparam int M =
    (K <= 1)    ? 2  :
    (K <= 4)    ? 3  :
    (K <= 11)   ? 4  :
    (K <= 26)   ? 5  :
    (K <= 57)   ? 6  :
    (K <= 120)  ? 7  :
    (K <= 247)  ? 8  :
    (K <= 502)  ? 9  :
    (K <= 1013) ? 10 :
    (K <= 2036) ? 11 :
    (K <= 4083) ? 12 : 13,
  localparam int N  = M + K,
  localparam int W  = N + 1,
  localparam int PW = $clog2(W)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [LANES*K-1:0]   d_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [1:0]           inj_mode_i,
  input  logic [PW-1:0]        inj_pos_i,
  output logic [LANES*W-1:0]   q_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [CNT_W-1:0]     cnt_o
);

  // Data bits go to non-power-of-2 positions; parity bits then
  // cover every position with their index bit set.
  function automatic logic [W-1:0] encode(
    input logic [K-1:0] d
  );
    logic [N:1] cw;
    logic       par;
    logic       p0;
    int         j;
    cw = '0;
    j  = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[j];
        j++;
      end
    end
    for (int i = 0; i < M; i++) begin
      par = 1'b0;
      for (int p = 1; p <= N; p++) begin
        if (p[i]) par ^= cw[p];
      end
      cw[1 << i] = par;
    end
    p0 = ^cw;
    if (P0_LSB != 0) return {cw, p0};
    else             return {p0, cw};
  endfunction

  // Flip pattern on the final word; positions past the word are ignored.
  function automatic logic [W-1:0] inj_mask(
    input logic [1:0]    mode,
    input logic [PW-1:0] pos
  );
    logic [W-1:0] mk;
    int           ip;
    mk = '0;
    ip = int'(pos);
    if (ip < W) begin
      case (mode)
        2'b01: mk[ip] = 1'b1;
        2'b10: begin
          mk[ip]           = 1'b1;
          mk[(ip + 1) % W] = 1'b1;
        end
        default: mk = '0;
      endcase
    end
    return mk;
  endfunction

  logic               s1_full;
  logic [LANES*K-1:0] s1_d;
  logic [1:0]         s1_mode;
  logic [PW-1:0]      s1_pos;
  logic               s2_full;
  logic               s2_open;
  logic               s1_take;
  logic [W-1:0]       flip;
  logic [LANES*W-1:0] enc_w;

  // Handshake: a stage opens when empty or draining this cycle.
  always_comb begin
    s2_open = !s2_full | ready_i;
    ready_o = !rst_i & (!s1_full | s2_open);
    s1_take = valid_i & ready_o;
  end

  // Stage 1 captures raw data and injection controls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_full <= 1'b0;
      s1_d    <= '0;
      s1_mode <= '0;
      s1_pos  <= '0;
    end else begin
      s1_full <= s1_take | (s1_full & !s2_open);
      if (s1_take) begin
        s1_d    <= d_i;
        s1_mode <= inj_mode_i;
        s1_pos  <= inj_pos_i;
      end
    end
  end

  // Encode every lane and apply the shared injection pattern.
  always_comb begin
    enc_w = '0;
    flip  = inj_mask(s1_mode, s1_pos);
    for (int l = 0; l < LANES; l++) begin
      enc_w[l*W +: W] = encode(s1_d[l*K +: K]) ^ flip;
    end
  end

  // Stage 2 holds the codewords; q only changes when a beat loads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_full <= 1'b0;
      q_o     <= '0;
    end else if (s2_open) begin
      s2_full <= s1_full;
      if (s1_full) q_o <= enc_w;
    end
  end

  assign valid_o = s2_full;

  // Count output transfers, wrapping naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_o <= '0;
    else if (s2_full & ready_i) cnt_o <= cnt_o + 1'b1;
  end

endmodule

// File: tb/tb_ecc_enc_pipe.sv
// Directed bench for ecc_enc_pipe: small config with both p0 placements,
// plus a two-lane K=32 config with a 4-bit beat counter.
module tb_ecc_enc_pipe;

  logic clk;
  logic rst;

  logic [3:0]  d_a;
  logic        valid_a;
  logic [1:0]  mode_a;
  logic [2:0]  pos_a;
  logic        rdy_a;
  logic        ready_a, ready_b;
  logic [7:0]  q_a, q_b;
  logic        vo_a, vo_b;
  logic [31:0] cnt_a, cnt_b;

  logic [63:0] d_c;
  logic        valid_c;
  logic [1:0]  mode_c;
  logic [5:0]  pos_c;
  logic        rdy_c;
  logic        ready_c;
  logic [77:0] q_c;
  logic        vo_c;
  logic [3:0]  cnt_c;

  int n_run;
  int n_fail;

  ecc_enc_pipe #(
    .K(4), .LANES(1), .P0_LSB(1), .CNT_W(32)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .d_i(d_a),
    .valid_i(valid_a), .ready_o(ready_a),
    .inj_mode_i(mode_a), .inj_pos_i(pos_a),
    .q_o(q_a), .valid_o(vo_a), .ready_i(rdy_a),
    .cnt_o(cnt_a)
  );

  ecc_enc_pipe #(
    .K(4), .LANES(1), .P0_LSB(0), .CNT_W(32)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .d_i(d_a),
    .valid_i(valid_a), .ready_o(ready_b),
    .inj_mode_i(mode_a), .inj_pos_i(pos_a),
    .q_o(q_b), .valid_o(vo_b), .ready_i(rdy_a),
    .cnt_o(cnt_b)
  );

  ecc_enc_pipe #(
    .K(32), .LANES(2), .P0_LSB(1), .CNT_W(4)
  ) dut_c (
    .clk_i(clk), .rst_i(rst), .d_i(d_c),
    .valid_i(valid_c), .ready_o(ready_c),
    .inj_mode_i(mode_c), .inj_pos_i(pos_c),
    .q_o(q_c), .valid_o(vo_c), .ready_i(rdy_c),
    .cnt_o(cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference for K=32: parity bits taken from the XOR of the
  // position indices of all set data bits (the syndrome form).
  function automatic logic [38:0] ref_enc(
    input logic [31:0] d,
    input logic [1:0]  md,
    input int          ps
  );
    logic [38:1] c;
    logic [38:0] w;
    int          s;
    int          j;
    c = '0;
    s = 0;
    j = 0;
    for (int p = 1; p <= 38; p++) begin
      if (!(p inside {1, 2, 4, 8, 16, 32})) begin
        c[p] = d[j];
        if (d[j]) s ^= p;
        j++;
      end
    end
    for (int i = 0; i < 6; i++) c[1 << i] = s[i];
    w = {c, ^c};
    if (ps < 39) begin
      if (md == 2'b01) w[ps] = ~w[ps];
      if (md == 2'b10) begin
        w[ps]            = ~w[ps];
        w[(ps + 1) % 39] = ~w[(ps + 1) % 39];
      end
    end
    return w;
  endfunction

  // One beat through the small configs; entered and left on a negedge.
  task automatic send_ab(
    input logic [3:0] d,
    input logic [1:0] md,
    input logic [2:0] ps,
    input logic [7:0] ea,
    input logic [7:0] eb
  );
    d_a = d; mode_a = md; pos_a = ps;
    valid_a = 1'b1; rdy_a = 1'b1;
    #1 chk("acc_ready", ready_a, 1);
    @(negedge clk);
    valid_a = 1'b0;
    #1 chk("lat1_valid", vo_a, 0);
    @(negedge clk);
    #1;
    chk("lat2_valid", vo_a, 1);
    chk("lat2_valid_b", vo_b, 1);
    chk("q_a", q_a, ea);
    chk("q_b", q_b, eb);
    @(negedge clk);
    #1;
    chk("drained", vo_a, 0);
    chk("q_idle_hold", q_a, ea);
  endtask

  logic [7:0]  bp_tab [10];
  logic [77:0] expq [$];
  logic [3:0]  xcnt;
  logic [7:0]  hq;
  logic        hold;
  logic        acc;
  logic        outx;
  int          sent, recv, occ, t;

  initial begin
    n_run = 0; n_fail = 0;
    bp_tab = '{8'h00, 8'h0F, 8'h33, 8'h3C, 8'h55,
               8'h5A, 8'h66, 8'h69, 8'h96, 8'h99};
    rst = 1'b1;
    d_a = '0; valid_a = 1'b0; mode_a = '0; pos_a = '0; rdy_a = 1'b0;
    d_c = '0; valid_c = 1'b0; mode_c = '0; pos_c = '0; rdy_c = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", ready_a, 0);
    chk("rst_valid", vo_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_q", q_a, 0);
    chk("rst_valid_c", vo_c, 0);
    rst = 1'b0;
    @(negedge clk);
    #1 chk("post_rst_ready", ready_a, 1);

    // Basic encode, p0 placement and injection
    send_ab(4'hB, 2'b00, 3'd0, 8'hAA, 8'h55);
    send_ab(4'hF, 2'b00, 3'd0, 8'hFF, 8'hFF);
    send_ab(4'h0, 2'b00, 3'd0, 8'h00, 8'h00);
    send_ab(4'hB, 2'b01, 3'd0, 8'hAB, 8'h54);
    send_ab(4'hB, 2'b10, 3'd0, 8'hA9, 8'h56);
    send_ab(4'hB, 2'b10, 3'd7, 8'h2B, 8'hD4);
    send_ab(4'hB, 2'b01, 3'd7, 8'h2A, 8'hD5);
    send_ab(4'hB, 2'b11, 3'd5, 8'hAA, 8'h55);
    chk("cnt_after_8", cnt_a, 8);

    // Backpressure stream with ready pattern 1,0,0,...
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mode_a = 2'b00; pos_a = '0;
    sent = 0; recv = 0; occ = 0; t = 0; hold = 1'b0; hq = '0;
    while (recv < 10 && t < 200) begin
      rdy_a   = (t % 3 == 0);
      valid_a = (sent < 10);
      d_a     = sent[3:0];
      #1;
      if (hold) begin
        chk("bp_stall_valid", vo_a, 1);
        chk("bp_stall_q", q_a, hq);
      end
      chk("bp_ready", ready_a, !(occ == 2 && !rdy_a));
      acc  = valid_a & ready_a;
      outx = vo_a & rdy_a;
      if (outx) begin
        chk("bp_q", q_a, bp_tab[recv]);
        recv++;
      end
      hold = vo_a & !rdy_a;
      hq   = q_a;
      if (acc) sent++;
      occ = occ + int'(acc) - int'(outx);
      t++;
      @(negedge clk);
    end
    valid_a = 1'b0;
    #1;
    chk("bp_beats", recv, 10);
    chk("bp_cnt", cnt_a, 10);

    // Mid-operation reset with both stages full
    rdy_a = 1'b0; valid_a = 1'b1; d_a = 4'h1;
    #1 chk("mr_acc1", ready_a, 1);
    @(negedge clk);
    d_a = 4'h2;
    #1 chk("mr_acc2", ready_a, 1);
    @(negedge clk);
    valid_a = 1'b0;
    #1;
    chk("mr_full_valid", vo_a, 1);
    chk("mr_full_ready", ready_a, 0);
    chk("mr_full_q", q_a, 8'h0F);
    rst = 1'b1;
    #1 chk("mr_rst_ready", ready_a, 0);
    @(negedge clk);
    #1;
    chk("mr_valid", vo_a, 0);
    chk("mr_cnt", cnt_a, 0);
    chk("mr_q", q_a, 0);
    rst = 1'b0;
    send_ab(4'h4, 2'b00, 3'd0, 8'h55, 8'hAA);

    // Two lanes, K=32, continuous ready, 4-bit counter wraps
    xcnt = '0;
    for (int k = 0; k < 22; k++) begin
      valid_c = (k < 20);
      d_c     = {$urandom(), $urandom()};
      mode_c  = 2'($urandom_range(0, 3));
      pos_c   = 6'($urandom_range(0, 63));
      rdy_c   = 1'b1;
      #1;
      if (valid_c) begin
        chk("ml_ready", ready_c, 1);
        expq.push_back({ref_enc(d_c[63:32], mode_c, int'(pos_c)),
                        ref_enc(d_c[31:0], mode_c, int'(pos_c))});
      end
      chk("ml_cnt", cnt_c, xcnt);
      if (k >= 2) begin
        chk("ml_valid", vo_c, 1);
        if (expq.size() > 0) chk("ml_q", q_c, expq.pop_front());
        xcnt++;
      end else begin
        chk("ml_valid_lat", vo_c, 0);
      end
      @(negedge clk);
    end
    valid_c = 1'b0;
    #1 chk("ml_cnt_end", cnt_c, 4'd4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
